// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register feeding the ALU: registered operand/control capture,
// ALU control decode, EX forwarding (macro ID_EX_FORWARD_EN) and load-use detection.
module id_ex_alu_issue #(
    parameter int N          = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [N-1:0]          id_rs1_data,
    input  logic [N-1:0]          id_rs2_data,
    input  logic [N-1:0]          id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic [2:0]            id_funct3,
    input  logic                  id_funct7_b5,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [N-1:0]          mem_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [N-1:0]          wb_result,
    output logic [N-1:0]          alu_a,
    output logic [N-1:0]          alu_b,
    output logic                  alu_carry_in,
    output logic [3:0]            alu_operation,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [N-1:0]          ex_store_data,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_illegal,
    output logic                  load_use_hazard
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic [REG_ADDR_W-1:0] rs1_q, rs2_q;
    logic [N-1:0]          rs1_data_q, rs2_data_q, imm_q;
    logic                  alu_src_q;
    logic [3:0]            dec_op;
    logic                  dec_illegal;
    logic [N-1:0]          fwd_rs1, fwd_rs2;

    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        case (id_alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            default: begin
                // funct7 bit 5 selects sub only for R-type; I-type addi ignores it
                case (id_funct3)
                    3'b000:  dec_op = (id_alu_op == 2'b10 && id_funct7_b5) ? OP_SUB : OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            alu_src_q     <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            alu_operation <= OP_ADD;
            ex_illegal    <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_rd         <= id_rd;
            rs1_q         <= id_rs1;
            rs2_q         <= id_rs2;
            rs1_data_q    <= id_rs1_data;
            rs2_data_q    <= id_rs2_data;
            imm_q         <= id_imm;
            alu_src_q     <= id_alu_src;
            ex_reg_write  <= id_reg_write  & id_valid;
            ex_mem_read   <= id_mem_read   & id_valid;
            ex_mem_write  <= id_mem_write  & id_valid;
            ex_mem_to_reg <= id_mem_to_reg & id_valid;
            alu_operation <= dec_op;
            ex_illegal    <= dec_illegal;
        end
    end

`ifdef ID_EX_FORWARD_EN
    function automatic logic [N-1:0] forward(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [N-1:0]          data,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic [N-1:0]          m_val,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic [N-1:0]          w_val
    );
        if (m_we && m_rd != '0 && m_rd == rs)
            return m_val;
        else if (w_we && w_rd != '0 && w_rd == rs)
            return w_val;
        else
            return data;
    endfunction

    always_comb begin
        fwd_rs1 = forward(rs1_q, rs1_data_q, mem_reg_write, mem_rd, mem_result,
                          wb_reg_write, wb_rd, wb_result);
        fwd_rs2 = forward(rs2_q, rs2_data_q, mem_reg_write, mem_rd, mem_result,
                          wb_reg_write, wb_rd, wb_result);
    end
`else
    logic fwd_unused;

    assign fwd_rs1    = rs1_data_q;
    assign fwd_rs2    = rs2_data_q;
    assign fwd_unused = ^{mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd,
                          wb_result, rs1_q, rs2_q};
`endif

    assign alu_a         = fwd_rs1;
    assign alu_b         = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_carry_in  = alu_operation[2];

    assign load_use_hazard = ex_valid && ex_mem_read && ex_rd != '0 &&
                             (ex_rd == id_rs1 || ex_rd == id_rs2) && id_valid;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: stimulus pushes expected outputs from a
// reference model; a negedge monitor pops and compares.
module tb_id_ex_alu_issue;

    localparam int N  = 64;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n, stall, flush, id_valid;
    logic [N-1:0]  id_rs1_data, id_rs2_data, id_imm;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic [1:0]    id_alu_op;
    logic          id_alu_src, id_funct7_b5;
    logic [2:0]    id_funct3;
    logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          mem_reg_write, wb_reg_write;
    logic [RW-1:0] mem_rd, wb_rd;
    logic [N-1:0]  mem_result, wb_result;
    logic [N-1:0]  alu_a, alu_b, ex_store_data;
    logic          alu_carry_in, ex_valid, ex_illegal, load_use_hazard;
    logic [3:0]    alu_operation;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    id_ex_alu_issue #(.N(N), .REG_ADDR_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
        .alu_operation(alu_operation), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [RW-1:0] rd, rs1, rs2;
        logic [N-1:0]  d1, d2, imm;
        logic          src, rw, mr, mw, mtr, ill;
        logic [3:0]    op;
    } instr_t;

    typedef struct {
        logic [N-1:0]  a, b, st;
        logic [3:0]    op;
        logic          cin, valid, rw, mr, mw, mtr, ill, luh;
        logic [RW-1:0] rd;
    } exp_t;

    instr_t m;
    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     stim_done = 0;

    function automatic instr_t bubble();
        instr_t b;
        b = '{valid: 1'b0, rd: '0, rs1: '0, rs2: '0, d1: '0, d2: '0, imm: '0,
              src: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, mtr: 1'b0, ill: 1'b0,
              op: 4'b0010};
        return b;
    endfunction

    // Reference ALU control: what operation the instruction means.
    function automatic void ref_decode(input logic [1:0] aop, input logic [2:0] f3,
                                       input logic f7, output logic [3:0] op,
                                       output logic ill);
        ill = 1'b0;
        if (aop == 2'd0)      op = 4'b0010;
        else if (aop == 2'd1) op = 4'b0110;
        else if (f3 == 3'd7)  op = 4'b0000;
        else if (f3 == 3'd6)  op = 4'b0001;
        else if (f3 == 3'd0)  op = (aop == 2'd2 && f7) ? 4'b0110 : 4'b0010;
        else begin op = 4'b0010; ill = 1'b1; end
    endfunction

    function automatic logic [N-1:0] ref_fwd(input logic [RW-1:0] rs, input logic [N-1:0] d);
`ifdef ID_EX_FORWARD_EN
        if (rs == 0) return d;
        if (mem_reg_write && mem_rd == rs) return mem_result;
        if (wb_reg_write && wb_rd == rs) return wb_result;
`endif
        return d;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.a     = ref_fwd(m.rs1, m.d1);
        e.st    = ref_fwd(m.rs2, m.d2);
        e.b     = m.src ? m.imm : e.st;
        e.op    = m.op;
        e.cin   = (m.op == 4'b0110);
        e.valid = m.valid;
        e.rd    = m.rd;
        e.rw = m.rw; e.mr = m.mr; e.mw = m.mw; e.mtr = m.mtr; e.ill = m.ill;
        e.luh   = m.valid && m.mr && m.rd != 0 && id_valid &&
                  (m.rd == id_rs1 || m.rd == id_rs2);
        return e;
    endfunction

    function automatic void model_step();
        if (!rst_n || flush) m = bubble();
        else if (!stall) begin
            m.valid = id_valid; m.rd = id_rd; m.rs1 = id_rs1; m.rs2 = id_rs2;
            m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm; m.src = id_alu_src;
            m.rw = id_reg_write && id_valid;  m.mr  = id_mem_read && id_valid;
            m.mw = id_mem_write && id_valid;  m.mtr = id_mem_to_reg && id_valid;
            ref_decode(id_alu_op, id_funct3, id_funct7_b5, m.op, m.ill);
        end
    endfunction

    task automatic apply();
        q.push_back(expect_now());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1; stall = 0; flush = 0; id_valid = 0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = '0; id_alu_src = 0;
        id_funct3 = '0; id_funct7_b5 = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        mem_reg_write = 0; wb_reg_write = 0; mem_rd = '0; wb_rd = '0;
        mem_result = '0; wb_result = '0;
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("alu_a", alu_a, e.a);
                check("alu_b", alu_b, e.b);
                check("store_data", ex_store_data, e.st);
                check("alu_operation", N'(alu_operation), N'(e.op));
                check("alu_carry_in", N'(alu_carry_in), N'(e.cin));
                check("ex_valid", N'(ex_valid), N'(e.valid));
                check("ex_rd", N'(ex_rd), N'(e.rd));
                check("ctrl", N'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
                      N'({e.rw, e.mr, e.mw, e.mtr}));
                check("ex_illegal", N'(ex_illegal), N'(e.ill));
                check("load_use_hazard", N'(load_use_hazard), N'(e.luh));
            end
        end
    end

    initial begin : stimulus
        set_idle();
        rst_n = 0; id_valid = 1;
        repeat (2) @(posedge clk);
        m = bubble();
        #1;
        // reset held with a valid instruction presented
        apply(); apply();
        // R-type sub 10 - 3
        set_idle();
        id_valid = 1; id_alu_op = 2'b10; id_funct3 = 3'b000; id_funct7_b5 = 1;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3; id_rs1_data = 64'd10; id_rs2_data = 64'd3;
        id_reg_write = 1;
        apply();
        // I-type or with f7b5 set, then illegal funct3
        id_alu_op = 2'b11; id_funct3 = 3'b110; id_imm = 64'hF0; id_alu_src = 1;
        apply();
        id_funct3 = 3'b010;
        apply();
        // forwarding on rs1=5: MEM beats WB, then WB alone, then x0
        set_idle();
        id_valid = 1; id_rs1 = 5'd5; id_rs1_data = 64'h11; id_rd = 5'd5;
        apply();
        id_valid = 0; stall = 1;
        mem_reg_write = 1; mem_rd = 5'd5; mem_result = 64'hAA;
        wb_reg_write = 1;  wb_rd = 5'd5;  wb_result = 64'hBB;
        apply();
        mem_reg_write = 0;
        apply();
        stall = 0; id_valid = 1; id_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        mem_reg_write = 1;
        apply(); apply();
        // stall three cycles, then stall+flush together
        set_idle();
        id_valid = 1; id_reg_write = 1; id_alu_op = 2'b01; id_rd = 5'd9;
        id_rs1_data = 64'h1234; id_rs2_data = 64'h5678;
        apply();
        stall = 1; id_rs1_data = 64'hDEAD; id_alu_op = 2'b00;
        repeat (3) apply();
        flush = 1;
        apply(); apply();
        // load-use: lw rd=7 in EX, ID reads rs2=7; then rd=0
        set_idle();
        id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_rd = 5'd7;
        apply();
        stall = 1; id_mem_read = 0; id_rs2 = 5'd7; id_rs1 = 5'd3;
        apply();
        stall = 0; id_mem_read = 1; id_rd = 5'd0; id_rs2 = 5'd0;
        apply();
        id_mem_read = 0;
        apply();
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            flush = ($urandom_range(0, 11) == 0);
            stall = ($urandom_range(0, 5) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_rs1_data = {$urandom, $urandom};
            id_rs2_data = ($urandom_range(0, 3) == 0) ? 64'(i) : {$urandom, $urandom};
            id_imm = {$urandom, $urandom};
            id_rs1 = RW'($urandom_range(0, 7));
            id_rs2 = RW'($urandom_range(0, 7));
            id_rd  = RW'($urandom_range(0, 7));
            id_alu_op = 2'($urandom); id_funct3 = 3'($urandom); id_funct7_b5 = 1'($urandom);
            id_alu_src = 1'($urandom);
            id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
            id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
            mem_reg_write = 1'($urandom); mem_rd = RW'($urandom_range(0, 7));
            wb_reg_write  = 1'($urandom); wb_rd  = RW'($urandom_range(0, 7));
            mem_result = {$urandom, $urandom}; wb_result = {$urandom, $urandom};
            apply();
        end
        set_idle();
        stim_done = 1;
    end

    initial begin : finisher
        int budget;
        wait (stim_done);
        budget = 20;
        while (q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: stimulus did not complete, expected completion before 200000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
